// File: rtl/qnigma_pkg.sv
// Shared types and constants for the qnigma transmit arbiter and the protocol
// core that maps the arbiter's sel output onto protocol channels.
package qnigma_pkg;

  typedef enum logic {
    ARB_PRIO = 1'b0,
    ARB_RR   = 1'b1
  } arb_mode_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_XMIT = 2'd2
  } arb_state_t;

  localparam int unsigned TX_TMO_MS_DEF = 200;

  localparam int unsigned CH_ICMP = 0;
  localparam int unsigned CH_TCP  = 1;
  localparam int unsigned CH_DNS  = 2;

  // Counter width able to hold lim; a disabled watchdog still needs one bit.
  function automatic int unsigned cnt_width(input int unsigned lim);
    return (lim < 1) ? 1 : $clog2(lim + 1);
  endfunction

endpackage

// File: rtl/qnigma_rr_pick.sv
// Rotating-priority picker: first set request at or above start_i, wrapping.
// With start_i tied to zero it degenerates to lowest-index-wins.
module qnigma_rr_pick
  import qnigma_pkg::*;
#(
  parameter  int unsigned N_CH  = 3,
  localparam int unsigned IDX_W = $clog2(N_CH)
) (
  input  logic [N_CH-1:0]  req_i,
  input  logic [IDX_W-1:0] start_i,
  output logic             valid_o,
  output logic [IDX_W-1:0] idx_o
);

  localparam int unsigned SUM_W = IDX_W + 1;

  logic [2*N_CH-1:0] dbl;
  logic [N_CH-1:0]   rot;
  logic [IDX_W-1:0]  off;
  logic [SUM_W-1:0]  sum;

  assign dbl = {req_i, req_i} >> start_i;
  assign rot = dbl[N_CH-1:0];

  // Scan downward so the lowest rotated offset is the last assignment.
  always_comb begin
    off = '0;
    for (int k = N_CH - 1; k >= 0; k--) begin
      if (rot[k]) off = IDX_W'(k);
    end
  end

  always_comb begin
    sum = {1'b0, start_i} + {1'b0, off};
    if (sum >= SUM_W'(N_CH)) sum = sum - SUM_W'(N_CH);
  end

  assign valid_o = |req_i;
  assign idx_o   = sum[IDX_W-1:0];

endmodule

// File: rtl/qnigma_tx_arb.sv
// N-channel transmit arbiter: grants one protocol engine at a time onto the
// shared IPv6/MAC TX path, holds its metadata, and aborts on a ms watchdog.
module qnigma_tx_arb
  import qnigma_pkg::*;
#(
  parameter  int unsigned N_CH   = 3,
  parameter  int unsigned META_W = 512,
  parameter  int unsigned RR     = 0,
  parameter  int unsigned TMO_MS = TX_TMO_MS_DEF,
  localparam int unsigned IDX_W  = $clog2(N_CH)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     tick_ms,
  input  logic [N_CH-1:0]          tx_pend,
  output logic [N_CH-1:0]          tx_acpt,
  output logic [N_CH-1:0]          tx_done_ch,
  input  logic [N_CH*META_W-1:0]   meta_in,
  output logic [META_W-1:0]        meta_out,
  output logic [IDX_W-1:0]         sel,
  output logic                     send,
  input  logic                     tx_busy,
  input  logic                     tx_done,
  output logic                     active,
  output logic                     tmo
);

  localparam int unsigned CNT_W = cnt_width(TMO_MS);
  localparam arb_mode_t   MODE  = (RR != 0) ? ARB_RR : ARB_PRIO;

  arb_state_t         state_q, state_d;
  logic               send_q, send_d;
  logic [N_CH-1:0]    acpt_q, acpt_d;
  logic               active_q, active_d;
  logic               tmo_q, tmo_d;
  logic [IDX_W-1:0]   sel_q, sel_d;
  logic [META_W-1:0]  meta_q, meta_d;
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic [IDX_W-1:0]   pick_start, pick_idx, rr_next;
  logic               pick_vld;
  logic [META_W-1:0]  pick_meta;
  logic [CNT_W-1:0]   cnt_inc;
  logic               expire, grant_end;

  assign pick_start = (MODE == ARB_RR) ? rr_ptr_q : '0;

  qnigma_rr_pick #(.N_CH(N_CH)) u_pick (
    .req_i   (tx_pend),
    .start_i (pick_start),
    .valid_o (pick_vld),
    .idx_o   (pick_idx)
  );

  always_comb begin
    pick_meta = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (pick_idx == IDX_W'(i)) pick_meta = meta_in[i*META_W +: META_W];
    end
  end

  // Saturating ms counter; expiry is flagged on the tick that reaches the limit.
  assign cnt_inc = (tick_ms && (cnt_q != {CNT_W{1'b1}})) ? cnt_q + CNT_W'(1) : cnt_q;
  assign expire  = (TMO_MS != 0) && (cnt_inc == CNT_W'(TMO_MS));
  assign rr_next = (sel_q == IDX_W'(N_CH - 1)) ? '0 : sel_q + IDX_W'(1);

  always_comb begin
    state_d   = state_q;
    send_d    = send_q;
    acpt_d    = '0;
    active_d  = active_q;
    tmo_d     = 1'b0;
    sel_d     = sel_q;
    meta_d    = meta_q;
    rr_ptr_d  = rr_ptr_q;
    cnt_d     = cnt_q;
    grant_end = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!tx_busy && pick_vld) begin
          state_d  = ST_REQ;
          sel_d    = pick_idx;
          meta_d   = pick_meta;
          send_d   = 1'b1;
          acpt_d   = N_CH'(1) << pick_idx;
          active_d = 1'b1;
          cnt_d    = '0;
        end
      end
      ST_REQ: begin
        cnt_d = cnt_inc;
        if (expire) begin
          state_d   = ST_IDLE;
          send_d    = 1'b0;
          active_d  = 1'b0;
          tmo_d     = 1'b1;
          grant_end = 1'b1;
        end else if (tx_busy) begin
          send_d  = 1'b0;
          state_d = ST_XMIT;
        end
      end
      ST_XMIT: begin
        cnt_d = cnt_inc;
        // A completion in the expiry cycle takes precedence over the abort.
        if (tx_done) begin
          state_d   = ST_IDLE;
          active_d  = 1'b0;
          grant_end = 1'b1;
        end else if (expire) begin
          state_d   = ST_IDLE;
          send_d    = 1'b0;
          active_d  = 1'b0;
          tmo_d     = 1'b1;
          grant_end = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (grant_end && (MODE == ARB_RR)) rr_ptr_d = rr_next;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      send_q   <= 1'b0;
      acpt_q   <= '0;
      active_q <= 1'b0;
      tmo_q    <= 1'b0;
      sel_q    <= '0;
      meta_q   <= '0;
      rr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      send_q   <= send_d;
      acpt_q   <= acpt_d;
      active_q <= active_d;
      tmo_q    <= tmo_d;
      sel_q    <= sel_d;
      meta_q   <= meta_d;
      rr_ptr_q <= rr_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    tx_done_ch = '0;
    if ((state_q == ST_XMIT) && tx_done) tx_done_ch = N_CH'(1) << sel_q;
  end

  assign tx_acpt  = acpt_q;
  assign meta_out = meta_q;
  assign sel      = sel_q;
  assign send     = send_q;
  assign active   = active_q;
  assign tmo      = tmo_q;

endmodule

// File: doc/qnigma_tx_arb.md
Name: qnigma_tx_arb

Overview:
Parametrised N-channel transmit arbiter for the protocol core. It sits between the protocol engines (ICMP, TCP, DNS, future UDP/DHCP channels) and the shared IPv6/MAC transmit path.
- Selects one pending channel using fixed-priority or round-robin arbitration.
- Muxes that channel's packed TX metadata into a registered output held stable for the whole transmission.
- Routes tx_done back only to the granted channel.
- Recovers via a millisecond watchdog if the transmit path never completes.

Parameters:
N_CH, 3, number of requesting channels (2..16); channel 0 is highest fixed priority.
META_W, 512, width of one channel's packed metadata word (MAC+IP+L4 meta).
RR, 0, arbitration mode: 0 = fixed priority (lowest index wins), 1 = round-robin.
TMO_MS, 200, watchdog limit in tick_ms periods; 0 disables the watchdog.
IDX_W, $clog2(N_CH), derived localparam; width of the channel index.

Ports:
clk  in  1  system clock; the only clock.
rst  in  1  synchronous, active-low reset (sampled on clk rising edge; 0 = reset).
tick_ms  in  1  one-cycle pulse every millisecond.
tx_pend  in  N_CH  per-channel request; level, held until that channel's tx_acpt.
tx_acpt  out  N_CH  one-hot, one-cycle grant pulse to the winning channel.
tx_done_ch  out  N_CH  per-channel completion pulse.
meta_in  in  N_CH*META_W  packed metadata; channel i occupies bits [i*META_W +: META_W].
meta_out  out  META_W  registered metadata of the granted channel.
sel  out  IDX_W  index of the granted channel (drives tx_proto decode downstream).
send  out  1  transmit request to the shared TX path.
tx_busy  in  1  shared TX path busy.
tx_done  in  1  shared TX path completion pulse.
active  out  1  high while a grant is outstanding.
tmo  out  1  one-cycle pulse when the watchdog aborts a grant.

Behaviour:
- Reset (rst==0 at a clk edge) forces: state IDLE; send, tx_acpt, tx_done_ch, active, tmo = 0; sel = 0; meta_out = 0; rr_ptr = 0; watchdog counter = 0. Reset mid-transmission drops the grant and forwards no tx_done_ch.
- States are IDLE, REQ and XMIT.
- IDLE:
  - If tx_busy==0 and |tx_pend, pick winner w.
  - RR=0: w is the lowest set index.
  - RR=1: w is the first set index searching upward from rr_ptr, wrapping N_CH-1 to 0.
  - Next cycle: sel<=w, meta_out<=meta_in[w], send<=1, tx_acpt[w]<=1 for exactly one cycle, active<=1, counter<=0, go to REQ.
  - If tx_busy==1, no grant is made.
- REQ: send stays 1 until tx_busy is sampled 1; then send<=0 and go to XMIT.
- XMIT: tx_done_ch[sel] = tx_done, combinational, only in this state; all other bits are 0. On tx_done: active<=0, go to IDLE.
- rr_ptr update: on every grant completion (done or timeout), rr_ptr <= (sel==N_CH-1) ? 0 : sel+1. The pointer is not modified in RR=0 mode.
- Watchdog:
  - In REQ and XMIT the counter increments on tick_ms, saturating.
  - When the counter reaches TMO_MS and TMO_MS != 0: tmo pulses 1 cycle, send<=0, active<=0, go to IDLE, and no tx_done_ch is issued.
  - tx_done in the same cycle as expiry: done wins and tmo stays 0.
- meta_out and sel are stable from grant until the next grant. They are never changed while active==1.
- tx_pend deassertion after a grant is ignored. tx_pend of other channels during a grant is held off.
- Back-to-back grants: at least one IDLE cycle between the tx_done/timeout cycle and the next send.
- tx_done outside XMIT is ignored.
- Latency: request in IDLE to send = 1 cycle.

Decomposition:
- qnigma_pkg: arb_mode_t (ARB_PRIO, ARB_RR); TX_TMO_MS_DEF; per-protocol channel index constants (CH_ICMP=0, CH_TCP=1, CH_DNS=2) so the core maps sel to proto_t.
- Sub-module qnigma_rr_pick: combinational rotating-priority picker. Inputs are the request vector and start index; outputs are valid and index. With start fixed at 0 it also serves fixed-priority mode.

Test Plan:
1. RR=0, tx_pend=3'b110 in IDLE -> next cycle tx_acpt=3'b010, sel=1, send=1, meta_out=meta_in[1]; tx_busy=1 -> send=0; tx_done -> tx_done_ch=3'b010 for 1 cycle.
2. RR=1, tx_pend held at 3'b111 over 6 transactions -> grant order 0,1,2,0,1,2; RR=0 with same stimulus -> 0,0,0,...
3. TMO_MS=3, grant then tx_busy stuck 1, no tx_done -> tmo pulses on the cycle after the 3rd tick_ms, active=0, tx_done_ch stays 0, next pending channel granted afterwards.
4. tx_busy=1 while tx_pend=3'b001 -> no send and no tx_acpt until tx_busy=0, then grant in 1 cycle; stray tx_done while IDLE -> tx_done_ch remains 0.
5. Change meta_in[sel] during XMIT -> meta_out unchanged until the next grant; tx_done coincident with watchdog expiry -> tx_done_ch pulses, tmo=0.
6. rst=0 asserted during XMIT -> next cycle all outputs at reset values, rr_ptr=0; subsequent tx_done produces no tx_done_ch.
